cdb_arbiter: RTL

- Responder side of the common-data-bus require/accept handshake.
- Takes per-unit CDB requests from the functional units (alu, mul, div, mem), picks one per cycle with round-robin fairness and returns the accept.
- Registers the winner's result and label onto the broadcast outputs (BCEN/BClabel/BCdata) that feed the register file, reservation stations and queues.
- Replaces the combinational priority helper plus mux pair with a single fair, registered block.

---
 rtl/cdb_pkg.sv | 19 +
 rtl/cdb_arbiter_rr_pick.sv | 50 +++++
 rtl/cdb_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the common-data-bus (CDB) blocks.
//   CDB_DATA_W  - default broadcast result width
//   CDB_LABEL_W - default reservation-station label width
//   LABEL_NONE  - label value meaning "no label"; such results are never broadcast
//   cdbSrc_e    - requester index of each functional unit on the CDB
package cdb_pkg;

  localparam int CDB_DATA_W  = 32;
  localparam int CDB_LABEL_W = 4;
  localparam int LABEL_NONE  = 0;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_DIV = 2'd2,
    SRC_MEM = 2'd3
  } cdbSrc_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
// Searches req starting at index ptr and wrapping modulo N. The first set
// index wins.
//   req   - request vector, one bit per requester
//   ptr   - index searched first (must be < N)
//   grant - one-hot winner, all zero when req is zero
//   idx   - binary winner index, 0 when req is zero
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] idx_s;

  // (base + step) mod N, for base and step both below N.
  function automatic logic [IDX_W-1:0] wrapAdd(input logic [IDX_W-1:0] base,
                                               input logic [IDX_W-1:0] step);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    return (sum >= (IDX_W + 1)'(N)) ? (sum[IDX_W-1:0] - IDX_W'(N)) : sum[IDX_W-1:0];
  endfunction

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    cand_s = {IDX_W{1'b0}};
    idx_s  = {IDX_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = wrapAdd(ptr, IDX_W'(k));
      idx_s  = req[cand_s] ? cand_s : idx_s;
    end
  end

  // Produce the one-hot form, suppressed when nobody requests.
  always_comb begin
    if (|req) begin
      grant = {{(N - 1){1'b0}}, 1'b1} << idx_s;
    end else begin
      grant = {N{1'b0}};
    end
  end

  assign idx = idx_s;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: responder side of the CDB require/accept handshake.
// Picks one requesting functional unit per cycle in round-robin order and
// accepts it combinationally. It then broadcasts that unit's result and label
// on the next rising edge.
//   clk       - clock, all state changes on the rising edge
//   nRST      - synchronous reset, active HIGH despite the name
//   require   - per-unit request, held until accepted
//   reqData   - packed results, unit i at [i*DATA_W +: DATA_W]
//   reqLabel  - packed labels, unit i at [i*LABEL_W +: LABEL_W]
//   requireAC - one-hot accept, same cycle as the grant (0 while in reset)
//   BCEN      - registered broadcast valid
//   BClabel   - registered broadcast label
//   BCdata    - registered broadcast data
//   lastGrant - registered one-hot of the latest winner, 0 if none since reset
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int LABEL_W = CDB_LABEL_W
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [N_SRC-1:0]           require,
  input  logic [N_SRC*DATA_W-1:0]    reqData,
  input  logic [N_SRC*LABEL_W-1:0]   reqLabel,
  output logic [N_SRC-1:0]           requireAC,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic [N_SRC-1:0]           lastGrant
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   nextPtr_s;
  logic [N_SRC-1:0]   pickGrant_s;
  logic [PTR_W-1:0]   pickIdx_s;
  logic [DATA_W-1:0]  winData_s;
  logic [LABEL_W-1:0] winLabel_s;
  logic               granted_s;
  logic               labelValid_s;
  logic               bcEn_r;
  logic [LABEL_W-1:0] bcLabel_r;
  logic [DATA_W-1:0]  bcData_r;
  logic [N_SRC-1:0]   lastGrant_r;

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (PTR_W)
  ) uPick (
    .req   (require),
    .ptr   (ptr_r),
    .grant (pickGrant_s),
    .idx   (pickIdx_s)
  );

  // Accept the picked unit, but never while reset is asserted.
  always_comb begin
    if (nRST) begin
      requireAC = {N_SRC{1'b0}};
    end else begin
      requireAC = pickGrant_s;
    end
  end

  assign granted_s    = |requireAC;
  assign winData_s    = reqData[int'(pickIdx_s) * DATA_W +: DATA_W];
  assign winLabel_s   = reqLabel[int'(pickIdx_s) * LABEL_W +: LABEL_W];
  assign labelValid_s = (winLabel_s != LABEL_W'(LABEL_NONE));

  // The pointer moves to the slot just past the winner, wrapping at N_SRC.
  always_comb begin
    if (pickIdx_s == PTR_W'(N_SRC - 1)) begin
      nextPtr_s = {PTR_W{1'b0}};
    end else begin
      nextPtr_s = pickIdx_s + PTR_W'(1);
    end
  end

  // Round-robin pointer and most-recent-winner record.
  always_ff @(posedge clk) begin
    if (nRST) begin
      ptr_r       <= {PTR_W{1'b0}};
      lastGrant_r <= {N_SRC{1'b0}};
    end else if (granted_s) begin
      ptr_r       <= nextPtr_s;
      lastGrant_r <= requireAC;
    end else begin
      ptr_r       <= ptr_r;
      lastGrant_r <= lastGrant_r;
    end
  end

  // Broadcast registers.
  // Label-0 results are accepted but dropped, so data and label hold for them.
  always_ff @(posedge clk) begin
    if (nRST) begin
      bcEn_r    <= 1'b0;
      bcLabel_r <= {LABEL_W{1'b0}};
      bcData_r  <= {DATA_W{1'b0}};
    end else if (granted_s && labelValid_s) begin
      bcEn_r    <= 1'b1;
      bcLabel_r <= winLabel_s;
      bcData_r  <= winData_s;
    end else begin
      bcEn_r    <= 1'b0;
      bcLabel_r <= bcLabel_r;
      bcData_r  <= bcData_r;
    end
  end

  assign BCEN      = bcEn_r;
  assign BClabel   = bcLabel_r;
  assign BCdata    = bcData_r;
  assign lastGrant = lastGrant_r;

endmodule
